act_fun_arbiter: RTL and testbench

Shares one FIXED_POINT_ACT_FUN instance among NUM_REQ neuron requesters using round-robin arbitration. Operations are serialized, one in flight at a time, so the unit's sticky per-operation OVERFLOW can be attributed to the correct requester. Sits between the neuron accumulators and the activation datapath inside a layer.

---
 rtl/act_fun_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_act_fun_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_fun_arbiter.sv
// rtl/act_fun_arbiter.sv - round-robin arbiter sharing one activation unit among NUM_REQ requesters
//
// One operation is in flight at a time so the activation unit's sticky
// overflow flag can be returned to the requester that caused it.
//
// Optional feature macro: ACT_FUN_ARB_TIMEOUT_EN
//   defined   : watchdog in WAIT, forced response (value 0, overflow 1) after TIMEOUT_CYCLES
//   undefined : WAIT holds until the activation unit answers
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_valid         per-requester request, held until its o_req_ready bit pulses
//   i_req_value         packed operands, requester i at [i*WIDTH +: WIDTH]
//   o_req_ready         one-hot acceptance pulse
//   o_rsp_value         shared result bus, holds until the next response
//   o_rsp_valid         one-hot result pulse
//   o_rsp_overflow      overflow of the returned result, qualified by |o_rsp_valid
//   o_af_value_out      operand to the activation unit
//   o_af_valid_out      operand strobe to the activation unit
//   i_af_value_in       result from the activation unit
//   i_af_valid_in       result strobe from the activation unit
//   i_af_overflow_in    sticky overflow from the activation unit
//   o_busy              high whenever the arbiter is not idle
//   o_grant_idx         index of the current or last granted requester

module act_fun_arbiter #(
    parameter int WIDTH          = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_value,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [WIDTH-1:0]           o_rsp_value,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    output logic                       o_rsp_overflow,
    output logic [WIDTH-1:0]           o_af_value_out,
    output logic                       o_af_valid_out,
    input  logic [WIDTH-1:0]           i_af_value_in,
    input  logic                       i_af_valid_in,
    input  logic                       i_af_overflow_in,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic                  r_af_valid_out;
    logic [WIDTH-1:0]      r_af_value_out;
    logic [WIDTH-1:0]      r_result;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_value;
    logic                  r_rsp_overflow;

    logic                  w_found;
    logic [IDX_W-1:0]      w_cand;
    logic [IDX_W-1:0]      w_gnt;
    logic [WIDTH-1:0]      w_gnt_value;
    logic [NUM_REQ-1:0]    w_gnt_onehot;
    logic [NUM_REQ-1:0]    w_rsp_onehot;
    logic                  w_grant;
    logic                  w_capture;
    logic                  w_respond;
    logic                  w_timeout;

    // Round-robin scan: start one past the last winner and wrap, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_gnt   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt_value  = '0;
        w_gnt_onehot = '0;
        w_rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == IDX_W'(i)) begin
                w_gnt_value     = i_req_value[i*WIDTH +: WIDTH];
                w_gnt_onehot[i] = 1'b1;
            end
            if (r_grant_idx == IDX_W'(i)) begin
                w_rsp_onehot[i] = 1'b1;
            end
        end
    end

`ifdef ACT_FUN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Counts completed WAIT cycles; zero in the first WAIT cycle.
    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_grant) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_respond   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real result in the limit cycle takes the normal path.
                if (i_af_valid_in) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
`ifdef ACT_FUN_ARB_TIMEOUT_EN
                else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            ST_SETTLE: begin
                // The activation unit's overflow register updates on the same
                // edge as its valid strobe, so it is only trustworthy here.
                w_respond   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr          <= IDX_W'(NUM_REQ - 1);
            r_grant_idx    <= '0;
            r_req_ready    <= '0;
            r_af_valid_out <= 1'b0;
            r_af_value_out <= '0;
            r_result       <= '0;
            r_rsp_valid    <= '0;
            r_rsp_value    <= '0;
            r_rsp_overflow <= 1'b0;
        end else begin
            r_req_ready    <= '0;
            r_af_valid_out <= 1'b0;
            r_rsp_valid    <= '0;
            if (w_grant) begin
                r_req_ready    <= w_gnt_onehot;
                r_af_valid_out <= 1'b1;
                r_af_value_out <= w_gnt_value;
                r_grant_idx    <= w_gnt;
                r_ptr          <= w_gnt;
            end
            if (w_capture) begin
                r_result <= i_af_value_in;
            end
            if (w_respond) begin
                r_rsp_valid    <= w_rsp_onehot;
                r_rsp_value    <= r_result;
                r_rsp_overflow <= i_af_overflow_in;
            end
            if (w_timeout) begin
                r_rsp_valid    <= w_rsp_onehot;
                r_rsp_value    <= '0;
                r_rsp_overflow <= 1'b1;
            end
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_af_valid_out = r_af_valid_out;
    assign o_af_value_out = r_af_value_out;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_value    = r_rsp_value;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_grant_idx    = r_grant_idx;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_act_fun_arbiter.sv
// tb/tb_act_fun_arbiter.sv - randomized self-checking bench for act_fun_arbiter
`timescale 1ns/1ps

module tb_act_fun_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int L    = 4;
    localparam int T    = 8;
    localparam int IW   = 2;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      rv = '0;
    logic [N*W-1:0]    rvals = '0;
    logic [N-1:0]      o_req_ready;
    logic [W-1:0]      o_rsp_value;
    logic [N-1:0]      o_rsp_valid;
    logic              o_rsp_overflow;
    logic [W-1:0]      o_af_value_out;
    logic              o_af_valid_out;
    logic [W-1:0]      af_value_in;
    logic              af_valid_in;
    logic              af_ovf_in;
    logic              o_busy;
    logic [IW-1:0]     o_grant_idx;

    always #5 clk = ~clk;

    act_fun_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(rv), .i_req_value(rvals), .o_req_ready(o_req_ready),
        .o_rsp_value(o_rsp_value), .o_rsp_valid(o_rsp_valid), .o_rsp_overflow(o_rsp_overflow),
        .o_af_value_out(o_af_value_out), .o_af_valid_out(o_af_valid_out),
        .i_af_value_in(af_value_in), .i_af_valid_in(af_valid_in), .i_af_overflow_in(af_ovf_in),
        .o_busy(o_busy), .o_grant_idx(o_grant_idx)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Activation unit model: hard-tanh in Q2.13, fixed latency L, sticky overflow
    function automatic logic [W-1:0] act_f(input logic [W-1:0] x);
        int v;
        v = $signed(x);
        if (v > 8192)  return 16'h2000;
        if (v < -8192) return 16'hE000;
        return x;
    endfunction

    function automatic logic act_ovf(input logic [W-1:0] x);
        int v;
        v = $signed(x);
        return (v > 16384) || (v < -16384);
    endfunction

    logic          pv [L] = '{default: 1'b0};
    logic [W-1:0]  pd [L] = '{default: '0};
    logic          po [L] = '{default: 1'b0};
    logic          ovf_r = 1'b0;
    bit            mute = 1'b0;
    logic          stray = 1'b0;
    logic [W-1:0]  stray_val = '0;

    always @(posedge clk) begin
        pv[0] <= o_af_valid_out && !mute;
        pd[0] <= act_f(o_af_value_out);
        po[0] <= act_ovf(o_af_value_out);
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
            po[k] <= po[k-1];
        end
        if (pv[L-2]) ovf_r <= po[L-2];
    end

    assign af_valid_in = pv[L-1] | stray;
    assign af_value_in = stray ? stray_val : pd[L-1];
    assign af_ovf_in   = ovf_r;

    // Reference: expected outputs per absolute cycle
    logic [N-1:0] e_ready  [MAXC];
    bit           e_afv    [MAXC];
    logic [W-1:0] e_afval  [MAXC];
    logic [N-1:0] e_rspv   [MAXC];
    logic [W-1:0] e_rspval [MAXC];
    bit           e_rspovf [MAXC];
    bit           e_busy   [MAXC];

    int           m_ptr, m_free, m_gidx;
    logic [W-1:0] m_rspval;
    bit           m_rspovf;
    bit           awaiting [N];
    int           gen_prob = 0;
    bit           withdraw_en = 0;
    bit           fixed_vals = 0;
    bit           ovf_mode = 0;

    int           gq[$];
    int           gcyc[$];
    int           rq_idx[$];
    int           rq_cyc[$];
    logic [W-1:0] rq_val[$];
    bit           rq_ovf[$];

    task automatic clear_from(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_ready[k] = '0; e_afv[k] = 0; e_afval[k] = '0;
            e_rspv[k] = '0; e_rspval[k] = '0; e_rspovf[k] = 0; e_busy[k] = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = N - 1; m_free = 0; m_gidx = 0; m_rspval = '0; m_rspovf = 0;
        for (int i = 0; i < N; i++) awaiting[i] = 0;
    endtask

    task automatic clear_rec();
        gq.delete(); gcyc.delete(); rq_idx.delete(); rq_cyc.delete(); rq_val.delete(); rq_ovf.delete();
    endtask

    function automatic logic [W-1:0] fixed_val(input int i);
        if (ovf_mode && i == 2) return 16'h7000;
        return W'(16'h0400 * (i + 1));
    endfunction

    // Predict what the arbiter does at the coming edge from the inputs now applied
    task automatic decide();
        int c, g, r;
        logic [W-1:0] v;
        c = cyc;
        if (rst_n !== 1'b1 || c < m_free || rv == '0) return;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && rv[idx]) g = idx;
        end
        v = rvals[g*W +: W];
        m_ptr = g;
        awaiting[g] = 1;
        e_ready[c+1] = N'(1) << g;
        e_afv[c+1]   = 1;
        e_afval[c+1] = v;
        if (!mute) begin
            r = c + 3 + L;
            e_rspv[r] = N'(1) << g; e_rspval[r] = act_f(v); e_rspovf[r] = act_ovf(v);
            m_free = r;
        end else begin
`ifdef ACT_FUN_ARB_TIMEOUT_EN
            r = c + 1 + T;
            e_rspv[r] = N'(1) << g; e_rspval[r] = '0; e_rspovf[r] = 1;
            m_free = r;
`else
            m_free = MAXC;
`endif
        end
        for (int b = c + 1; b < m_free && b < MAXC; b++) e_busy[b] = 1;
    endtask

    task automatic step();
        int c;
        decide();
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < N; i++) begin
            if (e_ready[c][i]) m_gidx = i;
            if (e_rspv[c][i]) begin m_rspval = e_rspval[c]; m_rspovf = e_rspovf[c]; end
        end
        check_eq("req_ready", o_req_ready, e_ready[c]);
        check_eq("af_valid_out", o_af_valid_out, e_afv[c]);
        if (e_afv[c]) check_eq("af_value_out", o_af_value_out, e_afval[c]);
        check_eq("rsp_valid", o_rsp_valid, e_rspv[c]);
        check_eq("rsp_value", o_rsp_value, m_rspval);
        check_eq("rsp_overflow", o_rsp_overflow, m_rspovf);
        check_eq("busy", o_busy, e_busy[c]);
        check_eq("grant_idx", o_grant_idx, m_gidx);
        if (|o_req_ready) begin gq.push_back(int'(o_grant_idx)); gcyc.push_back(c); end
        for (int i = 0; i < N; i++) begin
            if (o_rsp_valid[i]) begin
                rq_idx.push_back(i); rq_cyc.push_back(c); rq_val.push_back(o_rsp_value); rq_ovf.push_back(o_rsp_overflow);
            end
        end
        // Requester behaviour
        for (int i = 0; i < N; i++) begin
            if (o_req_ready[i]) begin awaiting[i] = 0; rv[i] = 1'b0; end
        end
        for (int i = 0; i < N; i++) begin
            if (awaiting[i]) continue;
            if (rv[i]) begin
                if (withdraw_en && $urandom_range(15) == 0) rv[i] = 1'b0;
            end else if (int'($urandom_range(99)) < gen_prob) begin
                rv[i] = 1'b1;
                rvals[i*W +: W] = fixed_vals ? fixed_val(i) : W'($urandom);
            end
        end
    endtask

    task automatic quiesce();
        int lim;
        gen_prob = 0; withdraw_en = 0;
        for (int i = 0; i < N; i++) if (!awaiting[i]) rv[i] = 1'b0;
        lim = 0;
        while ((cyc < m_free + L + 3 || rv != '0) && lim < 200) begin step(); lim++; end
        check_eq("quiesce_idle", o_busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_from(0);
        model_reset();
        repeat (3) step();
        check_eq("reset_grant_idx", o_grant_idx, 0);
        check_eq("reset_rsp_valid", o_rsp_valid, 0);
        rst_n = 1'b1;

        // All four requesting continuously from reset
        clear_rec();
        fixed_vals = 1; gen_prob = 100;
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rvals[i*W +: W] = fixed_val(i); end
        repeat (36) step();
        if (gq.size() >= 5) begin
            check_eq("rr_order0", gq[0], 0);
            check_eq("rr_order1", gq[1], 1);
            check_eq("rr_order2", gq[2], 2);
            check_eq("rr_order3", gq[3], 3);
            check_eq("rr_order4", gq[4], 0);
            for (int k = 1; k < 5; k++) check_eq("rr_spacing", gcyc[k] - gcyc[k-1], L + 3);
        end else check_eq("rr_grant_count", gq.size(), 5);
        for (int k = 0; k < rq_idx.size() && k < gq.size(); k++) check_eq("rr_route", rq_idx[k], gq[k]);
        quiesce();

        // Single request, 1.0 in Q2.13
        clear_rec();
        fixed_vals = 0;
        rv = 4'b0001; rvals[0 +: W] = 16'h2000;
        repeat (10) step();
        if (gq.size() == 1 && rq_idx.size() == 1) begin
            check_eq("single_grant", gq[0], 0);
            check_eq("single_latency", rq_cyc[0] - gcyc[0], L + 2);
            check_eq("single_value", rq_val[0], 16'h2000);
            check_eq("single_ovf", rq_ovf[0], 1'b0);
        end else check_eq("single_count", gq.size() * 10 + rq_idx.size(), 11);
        quiesce();

        // Overflow attribution: only requester 2 overflows
        clear_rec();
        fixed_vals = 1; ovf_mode = 1; gen_prob = 100;
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rvals[i*W +: W] = fixed_val(i); end
        repeat (40) step();
        quiesce();
        ovf_mode = 0;
        check_eq("ovf_resp_count", rq_idx.size() >= 4, 1'b1);
        for (int k = 0; k < rq_idx.size(); k++) check_eq("ovf_attrib", rq_ovf[k], rq_idx[k] == 2);

        // Stray AF_VALID_IN while idle
        stray_val = 16'h1234; stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (5) step();
        check_eq("stray_busy", o_busy, 1'b0);

        // Reset pulsed during WAIT; the late result must be ignored
        fixed_vals = 0;
        rv = 4'b0100; rvals[2*W +: W] = 16'h0800;
        repeat (3) step();
        check_eq("pre_reset_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", o_busy, 1'b0);
        check_eq("arst_grant_idx", o_grant_idx, 0);
        check_eq("arst_af_valid", o_af_valid_out, 1'b0);
        check_eq("arst_rsp_value", o_rsp_value, 0);
        clear_from(cyc + 1);
        model_reset();
        rv = '0;
        step();
        rst_n = 1'b1;
        repeat (L + 4) step();
        clear_rec();
        fixed_vals = 1; gen_prob = 100;
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rvals[i*W +: W] = fixed_val(i); end
        repeat (3) step();
        if (gq.size() > 0) check_eq("post_reset_grant", gq[0], 0);
        else check_eq("post_reset_grant_count", gq.size(), 1);
        quiesce();

        // Sparse wrap: pointer at 3, then 1010; requester 0 withdraws before grant
        fixed_vals = 0;
        rv = 4'b1000; rvals[3*W +: W] = 16'h0123;
        repeat (L + 4) step();
        clear_rec();
        rv = 4'b1010; rvals[1*W +: W] = 16'h0111; rvals[3*W +: W] = 16'h0333;
        repeat (2) step();
        rv[0] = 1'b1; rvals[0 +: W] = 16'h0999;
        repeat (2) step();
        rv[0] = 1'b0;
        repeat (2 * (L + 3) + 2) step();
        if (gq.size() == 2) begin
            check_eq("sparse_first", gq[0], 1);
            check_eq("sparse_second", gq[1], 3);
        end else check_eq("sparse_count", gq.size(), 2);
        quiesce();

        // Randomized traffic
        fixed_vals = 0; gen_prob = 30; withdraw_en = 1;
        repeat (1500) step();
        quiesce();

        // Activation unit never answers
        clear_rec();
        mute = 1;
        rv = 4'b0010; rvals[1*W +: W] = 16'h0321;
        repeat (T + L + 10) step();
`ifdef ACT_FUN_ARB_TIMEOUT_EN
        if (rq_idx.size() == 1) begin
            check_eq("timeout_idx", rq_idx[0], 1);
            check_eq("timeout_value", rq_val[0], 0);
            check_eq("timeout_ovf", rq_ovf[0], 1'b1);
        end else check_eq("timeout_count", rq_idx.size(), 1);
        check_eq("timeout_busy", o_busy, 1'b0);
`else
        check_eq("hang_rsp_count", rq_idx.size(), 0);
        check_eq("hang_busy", o_busy, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
